// File: rtl/motoro3_sixstep_gen_if.sv
// Control and gate-drive bundle of the six-step generator.
// master = controller side, slave = generator side.
interface motoro3_sixstep_gen_if #(
   parameter int FREQ_W = 10,
   parameter int DEAD_W = 4
);
   logic              m3start;
   logic              m3stop;
   logic              m3dir;
   logic [FREQ_W-1:0] m3freq;
   logic [DEAD_W-1:0] deadTime;
   logic              aH, aL, bH, bL, cH, cL;
   logic [2:0]        stepIdx;
   logic              running;
   logic              stepStrobe;
   logic [1:0]        dbg_state;

   modport master (
      output m3start, m3stop, m3dir, m3freq, deadTime,
      input  aH, aL, bH, bL, cH, cL, stepIdx, running, stepStrobe, dbg_state
   );
   modport slave (
      input  m3start, m3stop, m3dir, m3freq, deadTime,
      output aH, aL, bH, bL, cH, cL, stepIdx, running, stepStrobe, dbg_state
   );
endinterface

// File: rtl/motoro3_sixstep_gen.sv
// Six-step three-phase gate generator with dead band, soft-start ramp,
// direction/stop control and registered step status.
module motoro3_sixstep_gen #(
   parameter int FREQ_W     = 10,
   parameter int CNT_W      = 16,
   parameter int DEAD_W     = 4,
   parameter int RAMP_START = 1000,
   parameter int RAMP_STEP  = 8
) (
   input  logic                  clk,
   input  logic                  nRst,
   motoro3_sixstep_gen_if.slave  bus
);
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_DEAD = 2'd1, S_DRIVE = 2'd2} state_t;

   localparam logic [CNT_W-1:0] LP_START = CNT_W'(RAMP_START);
   localparam logic [CNT_W-1:0] LP_STEP  = CNT_W'(RAMP_STEP);
   localparam logic [CNT_W-1:0] LP_ONE   = CNT_W'(1);

   state_t           r_state, w_state_nx;
   logic [2:0]       r_step, w_step_nx;
   logic [CNT_W-1:0] r_period, w_period_nx;
   logic [CNT_W-1:0] r_cnt, w_cnt_nx;
   logic             r_strobe, w_strobe_nx;
   logic [5:0]       r_gates, w_gates_nx;
   logic             r_running;
   logic [CNT_W-1:0] w_target, w_dead, w_ramped;

   // Gate vector order {aH,aL,bH,bL,cH,cL}; exactly one high and one low side per step.
   function automatic logic [5:0] table_gates(input logic [2:0] step);
      case (step)
         3'd0:    table_gates = 6'b10_01_00;
         3'd1:    table_gates = 6'b10_00_01;
         3'd2:    table_gates = 6'b00_10_01;
         3'd3:    table_gates = 6'b01_10_00;
         3'd4:    table_gates = 6'b01_00_10;
         3'd5:    table_gates = 6'b00_01_10;
         default: table_gates = 6'b00_00_00;
      endcase
   endfunction

   assign w_target = CNT_W'(bus.m3freq);
   assign w_dead   = CNT_W'(bus.deadTime);

   // Speed-up is ramped without going below target; slow-down jumps straight to target.
   always_comb begin
      w_ramped = w_target;
      if (r_period > w_target) begin
         w_ramped = ((r_period - w_target) > LP_STEP) ? (r_period - LP_STEP) : w_target;
      end
   end

   always_comb begin
      w_state_nx  = r_state;
      w_step_nx   = r_step;
      w_period_nx = r_period;
      w_cnt_nx    = r_cnt;
      w_strobe_nx = 1'b0;
      if (bus.m3stop) begin
         w_state_nx = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.m3start && (w_target != '0)) begin
                  w_step_nx   = 3'd0;
                  w_period_nx = LP_START;
                  if (w_dead != '0) begin
                     w_state_nx = S_DEAD;
                     w_cnt_nx   = w_dead - LP_ONE;
                  end else begin
                     w_state_nx = S_DRIVE;
                     w_cnt_nx   = LP_START - LP_ONE;
                  end
               end
            end
            S_DEAD: begin
               if (r_cnt == '0) begin
                  w_state_nx = S_DRIVE;
                  w_cnt_nx   = r_period - LP_ONE;
               end else begin
                  w_cnt_nx = r_cnt - LP_ONE;
               end
            end
            S_DRIVE: begin
               if (r_cnt != '0) begin
                  w_cnt_nx = r_cnt - LP_ONE;
               end else if (w_target == '0) begin
                  w_state_nx = S_IDLE;
               end else begin
                  if (bus.m3dir) w_step_nx = (r_step == 3'd0) ? 3'd5 : r_step - 3'd1;
                  else           w_step_nx = (r_step == 3'd5) ? 3'd0 : r_step + 3'd1;
                  w_period_nx = w_ramped;
                  w_strobe_nx = 1'b1;
                  if (w_dead != '0) begin
                     w_state_nx = S_DEAD;
                     w_cnt_nx   = w_dead - LP_ONE;
                  end else begin
                     w_state_nx = S_DRIVE;
                     w_cnt_nx   = w_ramped - LP_ONE;
                  end
               end
            end
            default: w_state_nx = S_IDLE;
         endcase
      end
      w_gates_nx = (w_state_nx == S_DRIVE) ? table_gates(w_step_nx) : 6'b0;
   end

   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         r_state   <= S_IDLE;
         r_step    <= 3'd0;
         r_period  <= LP_START;
         r_cnt     <= '0;
         r_strobe  <= 1'b0;
         r_gates   <= 6'b0;
         r_running <= 1'b0;
      end else begin
         r_state   <= w_state_nx;
         r_step    <= w_step_nx;
         r_period  <= w_period_nx;
         r_cnt     <= w_cnt_nx;
         r_strobe  <= w_strobe_nx;
         r_gates   <= w_gates_nx;
         r_running <= (w_state_nx != S_IDLE);
      end
   end

   assign {bus.aH, bus.aL, bus.bH, bus.bL, bus.cH, bus.cL} = r_gates;
   assign bus.stepIdx    = r_step;
   assign bus.running    = r_running;
   assign bus.stepStrobe = r_strobe;
   assign bus.dbg_state  = r_state;
endmodule

// File: tb/tb_motoro3_sixstep_gen.sv
// Randomised and directed bench for motoro3_sixstep_gen against a
// step/phase-level reference model.
module tb_motoro3_sixstep_gen;
   localparam int FREQ_W     = 10;
   localparam int CNT_W      = 16;
   localparam int DEAD_W     = 4;
   localparam int RAMP_START = 20;
   localparam int RAMP_STEP  = 8;

   logic clk = 1'b0;
   logic nRst;
   always #5 clk = ~clk;

   motoro3_sixstep_gen_if #(.FREQ_W(FREQ_W), .DEAD_W(DEAD_W)) bus ();

   motoro3_sixstep_gen #(
      .FREQ_W(FREQ_W), .CNT_W(CNT_W), .DEAD_W(DEAD_W),
      .RAMP_START(RAMP_START), .RAMP_STEP(RAMP_STEP)
   ) dut (
      .clk  (clk),
      .nRst (nRst),
      .bus  (bus.slave)
   );

   int tests = 0;
   int fails = 0;

   // Reference model: phase 0 = stopped, 1 = all-off band, 2 = driving; left = cycles remaining.
   int m_mode, m_left, m_step, m_period, m_strobe;
   int hi_leg [6] = '{0, 0, 1, 1, 2, 2};
   int lo_leg [6] = '{1, 2, 2, 0, 0, 1};

   function automatic logic [5:0] leg_gates(input int s);
      logic [5:0] g;
      g = 6'b0;
      g[5 - 2*hi_leg[s]] = 1'b1;
      g[4 - 2*lo_leg[s]] = 1'b1;
      return g;
   endfunction

   always @(posedge clk or negedge nRst) begin : model
      int t, d;
      if (!nRst) begin
         m_mode = 0; m_left = 0; m_step = 0; m_period = RAMP_START; m_strobe = 0;
      end else begin
         t = int'(bus.m3freq);
         d = int'(bus.deadTime);
         m_strobe = 0;
         if (bus.m3stop) begin
            m_mode = 0;
         end else if (m_mode == 0) begin
            if (bus.m3start && t != 0) begin
               m_step = 0;
               m_period = RAMP_START;
               if (d != 0) begin m_mode = 1; m_left = d; end
               else begin m_mode = 2; m_left = m_period; end
            end
         end else if (m_mode == 1) begin
            m_left = m_left - 1;
            if (m_left == 0) begin m_mode = 2; m_left = m_period; end
         end else begin
            m_left = m_left - 1;
            if (m_left == 0) begin
               if (t == 0) m_mode = 0;
               else begin
                  m_step = bus.m3dir ? (m_step + 5) % 6 : (m_step + 1) % 6;
                  if (m_period > t) m_period = (m_period - RAMP_STEP > t) ? m_period - RAMP_STEP : t;
                  else m_period = t;
                  m_strobe = 1;
                  if (d != 0) begin m_mode = 1; m_left = d; end
                  else begin m_mode = 2; m_left = m_period; end
               end
            end
         end
      end
   end

   function automatic logic [10:0] exp_vec();
      return {(m_mode == 2) ? leg_gates(m_step) : 6'b0, 3'(m_step), m_mode != 0, m_strobe != 0};
   endfunction

   function automatic logic [10:0] obs_vec();
      return {bus.aH, bus.aL, bus.bH, bus.bL, bus.cH, bus.cL, bus.stepIdx, bus.running, bus.stepStrobe};
   endfunction

   // Shoot-through and index range monitor across every run.
   always @(negedge clk) begin
      if (nRst === 1'b1) begin
         tests++;
         if (((bus.aH & bus.aL) | (bus.bH & bus.bL) | (bus.cH & bus.cL)) !== 1'b0 || bus.stepIdx > 3'd5) begin
            fails++;
            $display("FAIL invariant: gates=%b stepIdx=%0d required no leg pair and stepIdx<=5",
                     obs_vec() >> 5, bus.stepIdx);
         end
      end
   end

   task automatic set_inputs(input logic start, input logic stop, input logic dir,
                             input int freq, input int dead);
      bus.m3start  = start;
      bus.m3stop   = stop;
      bus.m3dir    = dir;
      bus.m3freq   = FREQ_W'(freq);
      bus.deadTime = DEAD_W'(dead);
   endtask

   task automatic stop_motor();
      bus.m3start = 1'b0;
      bus.m3stop  = 1'b1;
      @(negedge clk);
      bus.m3stop  = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset();
      nRst = 1'b0;
      set_inputs(1'b0, 1'b0, 1'b0, 4, 2);
      repeat (2) @(negedge clk);
      tests++;
      if (obs_vec() !== 11'b0) begin
         fails++; $display("FAIL reset_state: got %b required %b", obs_vec(), 11'b0);
      end
      nRst = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         tests++;
         if (obs_vec() !== exp_vec() || bus.running !== 1'b0) begin
            fails++; $display("FAIL reset_idle: got %b required %b", obs_vec(), exp_vec());
         end
      end
   endtask

   task automatic test_forward();
      int seg;
      int len [8];
      int off [8];
      int seq [8];
      logic [10:0] o;
      for (int i = 0; i < 8; i++) begin len[i] = 0; off[i] = 0; seq[i] = -1; end
      seg = 0;
      set_inputs(1'b1, 1'b0, 1'b0, 4, 2);
      @(negedge clk);
      bus.m3start = 1'b0;
      for (int i = 0; i < 70; i++) begin
         o = obs_vec();
         tests++;
         if (o !== exp_vec()) begin
            fails++; $display("FAIL fwd_cycle %0d: got %b required %b", i, o, exp_vec());
         end
         if (o[0] && seg < 7) seg++;
         if (o[10:5] != 6'b0) len[seg]++;
         else if (o[1]) off[seg]++;
         seq[seg] = int'(o[4:2]);
         @(negedge clk);
      end
      tests++;
      if (seg != 7) begin fails++; $display("FAIL fwd_strobes: got %0d required 7", seg); end
      for (int i = 0; i < 7; i++) begin
         tests++;
         if (seq[i] != i % 6) begin fails++; $display("FAIL fwd_seq[%0d]: got %0d required %0d", i, seq[i], i % 6); end
         if (i < 6) begin
            tests++;
            if (len[i] != ((i == 0) ? 20 : (i == 1) ? 12 : 4)) begin
               fails++; $display("FAIL fwd_len[%0d]: got %0d required %0d", i, len[i], (i == 0) ? 20 : (i == 1) ? 12 : 4);
            end
            tests++;
            if (off[i] != 2) begin fails++; $display("FAIL fwd_dead[%0d]: got %0d required 2", i, off[i]); end
         end
      end
      stop_motor();
   endtask

   task automatic test_reverse();
      int seg;
      int len [6];
      int seq [6];
      int offc;
      logic [10:0] o;
      for (int i = 0; i < 6; i++) begin len[i] = 0; seq[i] = -1; end
      seg = 0; offc = 0;
      set_inputs(1'b1, 1'b0, 1'b1, 4, 0);
      @(negedge clk);
      bus.m3start = 1'b0;
      for (int i = 0; i < 46; i++) begin
         o = obs_vec();
         tests++;
         if (o !== exp_vec()) begin
            fails++; $display("FAIL rev_cycle %0d: got %b required %b", i, o, exp_vec());
         end
         if (o[0] && seg < 5) seg++;
         if (o[10:5] != 6'b0) len[seg]++;
         else offc++;
         seq[seg] = int'(o[4:2]);
         @(negedge clk);
      end
      tests++;
      if (offc != 0) begin fails++; $display("FAIL rev_offcycles: got %0d required 0", offc); end
      for (int i = 0; i < 5; i++) begin
         tests++;
         if (seq[i] != (6 - i) % 6) begin fails++; $display("FAIL rev_seq[%0d]: got %0d required %0d", i, seq[i], (6 - i) % 6); end
         if (i >= 2) begin
            tests++;
            if (len[i] != 4) begin fails++; $display("FAIL rev_len[%0d]: got %0d required 4", i, len[i]); end
         end
      end
      stop_motor();
   endtask

   task automatic test_stop();
      bit found;
      logic [10:0] o;
      found = 1'b0;
      set_inputs(1'b1, 1'b0, 1'b0, 4, 1);
      @(negedge clk);
      bus.m3start = 1'b0;
      for (int k = 0; k < 300 && !found; k++) begin
         o = obs_vec();
         if (o[4:2] == 3'd2 && o[10:5] != 6'b0) found = 1'b1;
         else @(negedge clk);
      end
      tests++;
      if (!found) begin fails++; $display("FAIL stop_wait: step 2 DRIVE not reached in 300 cycles"); end
      bus.m3stop  = 1'b1;
      bus.m3start = 1'b1;
      @(negedge clk);
      o = obs_vec();
      tests++;
      if (o[10:5] !== 6'b0 || o[1] !== 1'b0 || o[4:2] !== 3'd2) begin
         fails++; $display("FAIL stop_next: got gates=%b running=%b step=%0d required 000000/0/2", o[10:5], o[1], o[4:2]);
      end
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         tests++;
         if (obs_vec() !== exp_vec() || bus.running !== 1'b0) begin
            fails++; $display("FAIL stop_hold: got %b required %b", obs_vec(), exp_vec());
         end
      end
      bus.m3stop  = 1'b0;
      bus.m3start = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_slowdown();
      int ns, len_a, len_b;
      bit done;
      logic [10:0] o;
      ns = 0; len_a = 0; len_b = 0; done = 1'b0;
      set_inputs(1'b1, 1'b0, 1'($urandom_range(0, 1)), 4, 1);
      @(negedge clk);
      bus.m3start = 1'b0;
      for (int k = 0; k < 400 && !done; k++) begin
         o = obs_vec();
         tests++;
         if (o !== exp_vec()) begin
            fails++; $display("FAIL slow_cycle %0d: got %b required %b", k, o, exp_vec());
         end
         if (o[0]) begin
            ns++;
            if (ns == 3) bus.m3freq = FREQ_W'(30);
            if (ns == 5) bus.m3freq = FREQ_W'(0);
         end
         if (o[10:5] != 6'b0 && ns == 4) len_a++;
         if (o[10:5] != 6'b0 && ns == 5) len_b++;
         if (ns == 5 && !o[1]) done = 1'b1;
         else @(negedge clk);
      end
      tests++;
      if (!done) begin fails++; $display("FAIL slow_idle: IDLE not reached within 400 cycles"); end
      tests++;
      if (len_a != 30) begin fails++; $display("FAIL slow_len: got %0d required 30", len_a); end
      tests++;
      if (len_b != 30) begin fails++; $display("FAIL zero_last_len: got %0d required 30", len_b); end
      @(negedge clk);
   endtask

   task automatic test_async_reset();
      bit found;
      logic [10:0] o;
      for (int ph = 0; ph < 2; ph++) begin
         found = 1'b0;
         set_inputs(1'b1, 1'b0, 1'b0, 5, 3);
         @(negedge clk);
         bus.m3start = 1'b0;
         for (int k = 0; k < 200 && !found; k++) begin
            o = obs_vec();
            if (o[1] && ((ph == 0) ? (o[10:5] == 6'b0) : (o[10:5] != 6'b0) && k > 30)) found = 1'b1;
            else @(negedge clk);
         end
         tests++;
         if (!found) begin fails++; $display("FAIL arst_wait%0d: phase not reached", ph); end
         #1 nRst = 1'b0;
         #1;
         tests++;
         if (obs_vec() !== 11'b0) begin
            fails++; $display("FAIL arst_now%0d: got %b required %b", ph, obs_vec(), 11'b0);
         end
         @(negedge clk);
         nRst = 1'b1;
         for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            tests++;
            if (obs_vec() !== exp_vec() || bus.running !== 1'b0) begin
               fails++; $display("FAIL arst_idle%0d: got %b required %b", ph, obs_vec(), exp_vec());
            end
         end
      end
   endtask

   task automatic test_random();
      for (int r = 0; r < 6; r++) begin
         set_inputs(1'b1, 1'b0, 1'($urandom_range(0, 1)), $urandom_range(1, 12), $urandom_range(0, 3));
         @(negedge clk);
         bus.m3start = 1'b0;
         for (int i = 0; i < 300; i++) begin
            tests++;
            if (obs_vec() !== exp_vec()) begin
               fails++; $display("FAIL rand_cycle r%0d c%0d: got %b required %b", r, i, obs_vec(), exp_vec());
            end
            if ($urandom_range(0, 19) == 0) bus.m3freq = FREQ_W'($urandom_range(0, 12));
            if ($urandom_range(0, 19) == 0) bus.deadTime = DEAD_W'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) bus.m3dir = ~bus.m3dir;
            bus.m3start = ($urandom_range(0, 9) == 0);
            bus.m3stop  = ($urandom_range(0, 99) == 0);
            if (bus.m3freq == '0 && $urandom_range(0, 3) == 0) bus.m3freq = FREQ_W'($urandom_range(1, 12));
            @(negedge clk);
         end
         stop_motor();
      end
   endtask

   initial begin
      test_reset();
      test_forward();
      test_reverse();
      test_stop();
      test_slowdown();
      test_async_reset();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
